// File: rtl/gain_stream.sv
// gain_stream: per-channel quantized gain stage between two first-word-fall-through FIFOs.
// Gains are double-buffered and committed to the active bank on every channel-0 pop.
module gain_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int OUT_SHIFT  = 4,
  parameter int CHANNELS   = 2,
  parameter int SATURATE   = 1,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_full,
  output logic                  out_wr_en,
  input  logic                  gain_wr_en,
  input  logic [CW-1:0]         gain_ch,
  input  logic [31:0]           gain_in,
  output logic                  sat_flag,
  output logic                  busy
);

  localparam int PW = DATA_WIDTH + 32;
  localparam int RW = PW + OUT_SHIFT;
  localparam logic signed [31:0]   UNITY = 32'sd1 <<< BITS;
  localparam logic signed [RW-1:0] R_MAX = RW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  typedef enum logic [1:0] {S_READ, S_MULT, S_WRITE} state_t;

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic [CW-1:0]                  ch_q, ch_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic signed [PW-1:0]           prod_q, prod_d;
  logic signed [31:0]             shadow_q [CHANNELS];
  logic signed [31:0]             shadow_d [CHANNELS];
  logic signed [31:0]             active_q [CHANNELS];
  logic signed [31:0]             active_d [CHANNELS];
  logic                           sat_q, sat_d;

  logic signed [PW-1:0]           quot;
  logic signed [RW-1:0]           res;
  logic                           ovf;

  // Round toward zero: bias negative products before the arithmetic shift.
  always_comb begin
    quot = prod_q[PW-1] ? ((prod_q + PW'(2**BITS - 1)) >>> BITS) : (prod_q >>> BITS);
    res  = RW'(quot) <<< OUT_SHIFT;
    ovf  = (SATURATE != 0) && ((res > R_MAX) || (res < R_MIN));
    if (ovf) begin
      out_din = res[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      out_din = res[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    sat_d     = sat_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;

    unique case (state_q)
      S_READ: begin
        // Reset gating keeps the pop strobe low while reset is held with data waiting.
        if (!in_empty && !reset) begin
          in_rd_en = 1'b1;
          sample_d = in_dout;
          ch_d     = cnt_q;
          cnt_d    = (int'(cnt_q) == CHANNELS - 1) ? '0 : cnt_q + 1'b1;
          state_d  = S_MULT;
          if (cnt_q == '0) begin
            active_d = shadow_q;
          end
        end
      end
      S_MULT: begin
        prod_d  = PW'(sample_q) * PW'(active_q[ch_q]);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (ovf) begin
          sat_d = 1'b1;
        end
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_d   = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase

    // A write landing on a commit pop goes straight into the active bank too.
    if (gain_wr_en && (int'(gain_ch) < CHANNELS)) begin
      shadow_d[gain_ch] = gain_in;
      if (in_rd_en && (cnt_q == '0)) begin
        active_d[gain_ch] = gain_in;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_READ;
      sample_q <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      sat_q    <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= UNITY;
        active_q[c] <= UNITY;
      end
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      sat_q    <= sat_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign out_ch   = ch_q;
  assign sat_flag = sat_q;
  assign busy     = (state_q != S_READ);

endmodule

// File: tb/tb_gain_stream.sv
// Bench for gain_stream: FWFT FIFO driver, arithmetic reference model with a
// scoreboard queue, directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_gain_stream;

  localparam int DW   = 32;
  localparam int BITS = 10;
  localparam int OSH  = 4;
  localparam int CH   = 2;
  localparam int SAT  = 1;
  localparam int CW   = 1;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] out_din;
  logic [CW-1:0] out_ch;
  logic          out_full;
  logic          out_wr_en;
  logic          gain_wr_en;
  logic [CW-1:0] gain_ch;
  logic [31:0]   gain_in;
  logic          sat_flag;
  logic          busy;

  always #5 clock = ~clock;

  gain_stream #(
    .DATA_WIDTH(DW), .BITS(BITS), .OUT_SHIFT(OSH), .CHANNELS(CH), .SATURATE(SAT)
  ) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_din(out_din), .out_ch(out_ch), .out_full(out_full),
    .out_wr_en(out_wr_en), .gain_wr_en(gain_wr_en), .gain_ch(gain_ch),
    .gain_in(gain_in), .sat_flag(sat_flag), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Upstream FIFO: pops on the edge after in_rd_en is seen, flags refresh 2ns later.
  logic [31:0] in_fifo[$];
  bit          pop_pending = 1'b0;

  always @(posedge clock) begin
    if (pop_pending && in_fifo.size() != 0) void'(in_fifo.pop_front());
    pop_pending = 1'b0;
    #2;
    in_empty = (in_fifo.size() == 0);
    in_dout  = (in_fifo.size() == 0) ? '0 : in_fifo[0];
  end

  // Reference model
  typedef struct {
    logic [31:0] val;
    int          ch;
    bit          sat;
    int          cyc;
    int          fsnap;
  } exp_t;

  exp_t        exp_q[$];
  longint      m_act[CH];
  longint      m_shd[CH];
  int          m_cnt = 0;
  bit          m_sat = 1'b0;
  bit          sat_chk = 1'b0;
  int          cyc = 0;
  int          fulls = 0;
  logic [31:0] wr_val[$];
  int          wr_ch[$];

  function automatic exp_t predict(input logic [31:0] din, input longint g, input int ch);
    exp_t   e;
    longint p, q, r;
    p = longint'($signed(din)) * g;
    q = p / (longint'(1) <<< BITS);
    r = q * (longint'(1) <<< OSH);
    e.ch  = ch;
    e.sat = 1'b0;
    e.cyc = 0;
    e.fsnap = 0;
    if (SAT != 0 && r > MAXV) begin
      e.val = 32'(MAXV); e.sat = 1'b1;
    end else if (SAT != 0 && r < MINV) begin
      e.val = 32'(MINV); e.sat = 1'b1;
    end else begin
      e.val = 32'(r);
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    bit   commit;
    if (reset) begin
      exp_q.delete();
      m_cnt   = 0;
      m_sat   = 1'b0;
      sat_chk = 1'b0;
      for (int c = 0; c < CH; c++) begin
        m_act[c] = longint'(1) <<< BITS;
        m_shd[c] = longint'(1) <<< BITS;
      end
      chk("rst_in_rd_en", 32'(in_rd_en), 0);
      chk("rst_out_wr_en", 32'(out_wr_en), 0);
      chk("rst_out_din", out_din, 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      chk("rst_sat_flag", 32'(sat_flag), 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      if (sat_chk) begin
        chk("sat_flag", 32'(sat_flag), 32'(m_sat));
        sat_chk = 1'b0;
      end
      chk("rd_while_empty", 32'(in_rd_en & in_empty), 0);
      chk("wr_while_full", 32'(out_wr_en & out_full), 0);
      chk("rd_and_wr", 32'(in_rd_en & out_wr_en), 0);
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (out_wr_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_wr: got out_wr_en=1 with value 0x%08h, expected no write", out_din);
        end else begin
          e = exp_q.pop_front();
          chk("out_din", out_din, e.val);
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("lat_min", 32'((cyc - e.cyc) >= 2), 1);
          if (fulls == e.fsnap) chk("lat_exact", 32'(cyc - e.cyc), 2);
          m_sat   = m_sat | e.sat;
          sat_chk = 1'b1;
          wr_val.push_back(out_din);
          wr_ch.push_back(int'(out_ch));
        end
      end
      commit = in_rd_en && (m_cnt == 0);
      if (commit) m_act = m_shd;
      if (gain_wr_en && int'(gain_ch) < CH) begin
        m_shd[gain_ch] = longint'($signed(gain_in));
        if (commit) m_act[gain_ch] = longint'($signed(gain_in));
      end
      if (in_rd_en) begin
        e = predict(in_dout, m_act[m_cnt], m_cnt);
        e.cyc   = cyc;
        e.fsnap = fulls;
        exp_q.push_back(e);
        m_cnt = (m_cnt + 1) % CH;
      end
      pop_pending = in_rd_en;
      fulls += int'(out_full);
      cyc++;
    end
  end

  // Stimulus helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    in_fifo.push_back(v);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((in_fifo.size() != 0 || exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    tick();
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got %0d pending samples, expected 0", exp_q.size());
    end
  endtask

  task automatic gain_write(input int ch, input logic [31:0] g);
    gain_wr_en = 1'b1;
    gain_ch    = CW'(ch);
    gain_in    = g;
    tick();
    gain_wr_en = 1'b0;
  endtask

  task automatic sync_ch0();
    if (m_cnt != 0) begin
      push('0);
      wait_idle();
    end
  endtask

  task automatic expect_wr(input string name, input int idx, input logic [31:0] v, input int ch);
    if (idx >= wr_val.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no write, expected 0x%08h", name, v);
    end else begin
      chk(name, wr_val[idx], v);
      chk({name, "_ch"}, 32'(wr_ch[idx]), 32'(ch));
    end
  endtask

  function automatic logic [31:0] rand_sample();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h8000_0000;
    if (k == 1) return 32'h7FFF_FFFF;
    if (k < 6)  return 32'($urandom_range(0, 2000)) - 32'd1000;
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_gain();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h8000_0000;
    if (k < 6)  return 32'($urandom_range(0, 4096)) - 32'd2048;
    if (k == 6) return $urandom;
    return 32'd1024;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] od;
    logic [CW-1:0] oc;
    int bp_ch, nw, n;

    reset = 1'b1; out_full = 1'b0; gain_wr_en = 1'b0; gain_ch = '0; gain_in = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Unity gain
    wr_val.delete(); wr_ch.delete();
    push(32'd100); push(-32'sd100);
    wait_idle();
    expect_wr("unity_pos", 0, 32'd1600, 0);
    expect_wr("unity_neg", 1, -32'sd1600, 1);

    // Round toward zero with gain 0.5
    sync_ch0();
    wr_val.delete(); wr_ch.delete();
    gain_write(0, 32'd512);
    push(-32'sd3); push(32'd0); push(32'd3);
    wait_idle();
    expect_wr("round_neg", 0, -32'sd16, 0);
    expect_wr("round_ch1", 1, 32'd0, 1);
    expect_wr("round_pos", 2, 32'd16, 0);
    gain_write(0, 32'd1024);

    // Saturation, sticky flag
    sync_ch0();
    wr_val.delete(); wr_ch.delete();
    push(32'h4000_0000); push(32'd5);
    wait_idle();
    expect_wr("sat_max", 0, 32'h7FFF_FFFF, 0);
    expect_wr("sat_after", 1, 32'd80, 1);
    chk("sat_sticky", 32'(sat_flag), 1);

    // Backpressure hold
    wr_val.delete(); wr_ch.delete();
    out_full = 1'b1;
    bp_ch = m_cnt;
    push(32'd7);
    repeat (3) tick();
    push(32'd9);
    od = out_din; oc = out_ch;
    chk("bp_value", od, 32'd112);
    chk("bp_ch", 32'(oc), 32'(bp_ch));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_din_stable", out_din, od);
      chk("bp_ch_stable", 32'(out_ch), 32'(oc));
      chk("bp_no_rd", 32'(in_rd_en), 0);
      chk("bp_no_wr", 32'(out_wr_en), 0);
    end
    out_full = 1'b0;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (out_wr_en) nw++;
    end
    chk("bp_one_write", 32'(nw), 1);
    wait_idle();

    // Frame-aligned gain update
    sync_ch0();
    wr_val.delete(); wr_ch.delete();
    push(32'd10); push(32'd10);
    n = 0;
    while (in_fifo.size() != 0 && n < 50) begin tick(); n++; end
    gain_write(0, 32'd2048);
    wait_idle();
    push(32'd10);
    wait_idle();
    expect_wr("frame_ch0_old", 0, 32'd160, 0);
    expect_wr("frame_ch1", 1, 32'd160, 1);
    expect_wr("frame_ch0_new", 2, 32'd320, 0);

    // Write coinciding with a channel-0 pop
    push(32'd10);
    wait_idle();
    wr_val.delete(); wr_ch.delete();
    gain_wr_en = 1'b1; gain_ch = '0; gain_in = 32'd3072;
    push(32'd10);
    tick();
    gain_wr_en = 1'b0;
    wait_idle();
    expect_wr("write_through", 0, 32'd480, 0);

    // Reset while a sample is in S_MULT
    push(32'd10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_wr", 32'(out_wr_en), 0);
    end
    wr_val.delete(); wr_ch.delete();
    push(32'd7);
    wait_idle();
    expect_wr("post_rst_unity", 0, 32'd112, 0);
    chk("post_rst_sat", 32'(sat_flag), 0);

    // Full-scale negative product
    sync_ch0();
    wr_val.delete(); wr_ch.delete();
    gain_write(0, 32'h8000_0000);
    push(32'h8000_0000);
    wait_idle();
    expect_wr("fullscale_neg", 0, 32'h7FFF_FFFF, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_full = ($urandom_range(0, 9) < 3);
      if (in_fifo.size() < 3 && $urandom_range(0, 1) == 1) push(rand_sample());
      if ($urandom_range(0, 9) == 0) begin
        gain_wr_en = 1'b1;
        gain_ch    = CW'($urandom_range(0, CH - 1));
        gain_in    = rand_gain();
      end else begin
        gain_wr_en = 1'b0;
      end
      tick();
    end
    gain_wr_en = 1'b0;
    out_full   = 1'b0;
    wait_idle();
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
